// File: rtl/formant_freq_sorter_if.sv
// Purpose: frame-level bus between the phi stage, the formant sorter and its consumer.
//   phi_data/phi_valid   : angle frame from the phi stage (master -> slave)
//   freq_out/freq_valid  : sorted frequency frame (slave -> master)
//   freq_ready           : consumer accept (master -> slave)
//   busy/drop_count      : sorter status (slave -> master)
interface formant_freq_sorter_if #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned FORMANTS  = 5
);
  logic [FORMANTS-1:0][BIT_WIDTH-1:0] phi_data;
  logic                               phi_valid;
  logic [FORMANTS-1:0][15:0]          freq_out;
  logic                               freq_valid;
  logic                               freq_ready;
  logic                               busy;
  logic [7:0]                         drop_count;

  modport master (
    output phi_data, phi_valid, freq_ready,
    input  freq_out, freq_valid, busy, drop_count
  );

  modport slave (
    input  phi_data, phi_valid, freq_ready,
    output freq_out, freq_valid, busy, drop_count
  );
endinterface

// File: rtl/formant_freq_sorter.sv
// Purpose: converts a frame of normalised formant angles to Hz (one shared
// multiplier, one formant per cycle), clamps, sorts ascending with an
// odd-even transposition network (one pass per cycle), optionally smooths
// against the previous delivered frame, and holds the result on a
// valid/ready handshake.
// Optional feature macro: FORMANT_SMOOTH_EN (adds the SMOOTH state and history).
// Ports:
//   clk_in  - system clock
//   rst_in  - asynchronous active-low reset
//   bus     - slave modport: phi_data/phi_valid in, freq_out/freq_valid out,
//             freq_ready in, busy/drop_count status out
module formant_freq_sorter #(
  parameter int unsigned BIT_WIDTH    = 32,
  parameter int unsigned FORMANTS     = 5,
  parameter int unsigned SAMPLE_RATE  = 16000,
  parameter int unsigned MAX_FREQ     = 5000
`ifdef FORMANT_SMOOTH_EN
  ,
  parameter int unsigned SMOOTH_SHIFT = 2
`endif
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  formant_freq_sorter_if.slave   bus
);

  localparam int unsigned PW        = 2 * BIT_WIDTH;
  localparam int unsigned IDX_W     = (FORMANTS > 1) ? $clog2(FORMANTS) : 1;
  localparam int unsigned HALF_RATE = SAMPLE_RATE / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FORMANTS - 1);

`ifdef FORMANT_SMOOTH_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_SORT    = 3'd2,
    S_SMOOTH  = 3'd3,
    S_HOLD    = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_SORT    = 2'd2,
    S_HOLD    = 2'd3
  } state_e;
`endif

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [IDX_W-1:0]                   pass_q, pass_d;
  logic [FORMANTS-1:0][BIT_WIDTH-1:0] phi_q, phi_d;
  logic [FORMANTS-1:0][15:0]          work_q, work_d;
  logic [FORMANTS-1:0][15:0]          freq_out_q, freq_out_d;
  logic                               freq_valid_q, freq_valid_d;
  logic                               busy_q, busy_d;
  logic [7:0]                         drop_q, drop_d;
`ifdef FORMANT_SMOOTH_EN
  logic                               hist_q, hist_d;
  logic [FORMANTS-1:0][15:0]          smooth_c;
`endif

  logic [PW-1:0]                      freq_full_c;
  logic [15:0]                        conv_c;
  logic [FORMANTS-1:0][15:0]          pass_c;
  logic [7:0]                         drop_inc_c;

  // Shared multiplier: Hz = phi * Nyquist / 2^BIT_WIDTH, truncated, then clamped.
  always_comb begin
    freq_full_c = (PW'(phi_q[idx_q]) * PW'(HALF_RATE)) >> BIT_WIDTH;
    if (freq_full_c > PW'(MAX_FREQ)) begin
      conv_c = 16'(MAX_FREQ);
    end else begin
      conv_c = 16'(freq_full_c);
    end
  end

  // One odd-even transposition pass; even passes pair (0,1),(2,3)..., odd (1,2),(3,4)...
  // Pairs within a pass are disjoint, so reading work_q and writing pass_c is safe.
  always_comb begin
    pass_c = work_q;
    for (int i = 0; i < int'(FORMANTS) - 1; i++) begin
      if ((1'(i) == pass_q[0]) && (work_q[i] > work_q[i+1])) begin
        pass_c[i]   = work_q[i+1];
        pass_c[i+1] = work_q[i];
      end
    end
  end

`ifdef FORMANT_SMOOTH_EN
  // y = prev + ((x - prev) >>> SMOOTH_SHIFT); result always lies between prev and x.
  always_comb begin
    for (int i = 0; i < int'(FORMANTS); i++) begin
      logic signed [16:0] diff;
      logic signed [16:0] sum;
      diff        = $signed({1'b0, work_q[i]}) - $signed({1'b0, freq_out_q[i]});
      sum         = $signed({1'b0, freq_out_q[i]}) + (diff >>> SMOOTH_SHIFT);
      smooth_c[i] = sum[15:0];
    end
  end
`endif

  assign drop_inc_c = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    phi_d        = phi_q;
    work_d       = work_q;
    freq_out_d   = freq_out_q;
    freq_valid_d = freq_valid_q;
    drop_d       = drop_q;
`ifdef FORMANT_SMOOTH_EN
    hist_d       = hist_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.phi_valid) begin
          phi_d   = bus.phi_data;
          idx_d   = '0;
          state_d = S_CONVERT;
        end
      end

      S_CONVERT: begin
        if (bus.phi_valid) drop_d = drop_inc_c;
        work_d[idx_q] = conv_c;
        if (idx_q == LAST_IDX) begin
          pass_d  = '0;
          state_d = S_SORT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_SORT: begin
        if (bus.phi_valid) drop_d = drop_inc_c;
        work_d = pass_c;
        if (pass_q == LAST_IDX) begin
`ifdef FORMANT_SMOOTH_EN
          state_d = S_SMOOTH;
`else
          freq_out_d   = pass_c;
          freq_valid_d = 1'b1;
          state_d      = S_HOLD;
`endif
        end else begin
          pass_d = pass_q + IDX_W'(1);
        end
      end

`ifdef FORMANT_SMOOTH_EN
      S_SMOOTH: begin
        if (bus.phi_valid) drop_d = drop_inc_c;
        // First frame after reset has no valid history and passes straight through.
        freq_out_d   = hist_q ? smooth_c : work_q;
        hist_d       = 1'b1;
        freq_valid_d = 1'b1;
        state_d      = S_HOLD;
      end
`endif

      S_HOLD: begin
        if (bus.freq_ready) begin
          freq_valid_d = 1'b0;
          // A frame arriving on the handshake cycle is taken, not dropped.
          if (bus.phi_valid) begin
            phi_d   = bus.phi_data;
            idx_d   = '0;
            state_d = S_CONVERT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (bus.phi_valid) begin
          drop_d = drop_inc_c;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pass_q       <= '0;
      phi_q        <= '0;
      work_q       <= '0;
      freq_out_q   <= '0;
      freq_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= '0;
`ifdef FORMANT_SMOOTH_EN
      hist_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      phi_q        <= phi_d;
      work_q       <= work_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
`ifdef FORMANT_SMOOTH_EN
      hist_q       <= hist_d;
`endif
    end
  end

  assign bus.freq_out   = freq_out_q;
  assign bus.freq_valid = freq_valid_q;
  assign bus.busy       = busy_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_formant_freq_sorter.sv
// Directed bench for formant_freq_sorter: conversion, clamp, latency,
// backpressure/drop, handshake-cycle acceptance, smoothing and mid-frame reset.
module tb_formant_freq_sorter;

`ifdef FORMANT_SMOOTH_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 11;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  formant_freq_sorter_if #(.BIT_WIDTH(32), .FORMANTS(5)) bus ();

  formant_freq_sorter dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [4:0][15:0] exp);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("%s[%0d]", tag, i), 64'(bus.freq_out[i]), 64'(exp[i]));
  endtask

  task automatic do_reset();
    bus.phi_valid  = 1'b0;
    bus.phi_data   = '0;
    bus.freq_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives phi_valid for one cycle (cycle 0); returns in cycle 1.
  task automatic send_frame(input logic [4:0][31:0] p);
    @(posedge clk); #1;
    bus.phi_data  = p;
    bus.phi_valid = 1'b1;
    @(posedge clk); #1;
    bus.phi_valid = 1'b0;
  endtask

  // Counts cycles (starting at 1) until freq_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.freq_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [4:0][31:0] phi_mix, phi_all;
  logic [4:0][15:0] exp_f;
  int lat;
  int pulses;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    phi_mix = {32'h6000_0000, 32'h1000_0000, 32'h8000_0000, 32'h4000_0000, 32'h2000_0000};

    // Reset state
    do_reset();
    check_eq("rst_valid", 64'(bus.freq_valid), 64'd0);
    check_eq("rst_busy",  64'(bus.busy),       64'd0);
    check_eq("rst_drop",  64'(bus.drop_count), 64'd0);
    check_eq("rst_out",   64'(bus.freq_out[0]) | 64'(bus.freq_out[4]), 64'd0);

    // Conversion, sort and latency
    send_frame(phi_mix);
    check_eq("busy_convert", 64'(bus.busy), 64'd1);
    wait_valid(lat);
    check_eq("latency", 64'(lat), 64'(LAT));
    check_frame("conv", {16'd4000, 16'd3000, 16'd2000, 16'd1000, 16'd500});
    @(posedge clk); #1;
    check_eq("pulse_end", 64'(bus.freq_valid), 64'd0);
    check_eq("idle_busy", 64'(bus.busy), 64'd0);
    check_frame("conv_held", {16'd4000, 16'd3000, 16'd2000, 16'd1000, 16'd500});

    // Clamp above MAX_FREQ
    do_reset();
    phi_all = {5{32'hC000_0000}};
    send_frame(phi_all);
    wait_valid(lat);
    check_frame("clamp", {5{16'd5000}});

    // All-zero angles
    do_reset();
    phi_all = '0;
    send_frame(phi_all);
    wait_valid(lat);
    check_eq("zero_lat", 64'(lat), 64'(LAT));
    check_frame("zero", '0);

    // Backpressure: ready low 30 cycles, second frame at cycle 20 is dropped
    do_reset();
    bus.freq_ready = 1'b0;
    @(posedge clk); #1;
    bus.phi_data  = phi_mix;
    bus.phi_valid = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      bus.phi_valid = 1'b0;
      if (c == 20) begin
        bus.phi_data  = {5{32'h1000_0000}};
        bus.phi_valid = 1'b1;
      end
    end
    check_eq("bp_valid", 64'(bus.freq_valid), 64'd1);
    check_eq("bp_drop",  64'(bus.drop_count), 64'd1);
    check_frame("bp_frame", {16'd4000, 16'd3000, 16'd2000, 16'd1000, 16'd500});
    bus.freq_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.freq_valid) pulses++;
    end
    check_eq("bp_single", 64'(pulses), 64'd0);
    check_eq("bp_idle", 64'(bus.busy), 64'd0);

    // Frame arriving on the handshake cycle is accepted
    do_reset();
    bus.freq_ready = 1'b0;
    send_frame(phi_mix);
    wait_valid(lat);
    repeat (3) @(posedge clk);
    #1;
    bus.phi_data   = {5{32'h4000_0000}};
    bus.phi_valid  = 1'b1;
    bus.freq_ready = 1'b1;
    @(posedge clk); #1;
    bus.phi_valid = 1'b0;
    check_eq("hs_valid_low", 64'(bus.freq_valid), 64'd0);
    check_eq("hs_busy", 64'(bus.busy), 64'd1);
    wait_valid(lat);
    check_eq("hs_lat",  64'(lat), 64'(LAT));
    check_eq("hs_drop", 64'(bus.drop_count), 64'd0);
`ifdef FORMANT_SMOOTH_EN
    exp_f = {16'd3500, 16'd2750, 16'd2000, 16'd1250, 16'd875};
`else
    exp_f = {5{16'd2000}};
`endif
    check_frame("hs_frame", exp_f);

    // Smoothing across two frames
    do_reset();
    send_frame({5{32'h2000_0000}});
    wait_valid(lat);
    check_frame("sm_a", {5{16'd1000}});
    send_frame({5{32'h4000_0000}});
    wait_valid(lat);
`ifdef FORMANT_SMOOTH_EN
    exp_f = {5{16'd1250}};
`else
    exp_f = {5{16'd2000}};
`endif
    check_frame("sm_b", exp_f);

    // Reset during SORT: nothing emitted, outputs cleared, history cleared
    do_reset();
    send_frame({5{32'h2000_0000}});
    wait_valid(lat);
    send_frame(phi_mix);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mr_valid", 64'(bus.freq_valid), 64'd0);
    check_eq("mr_busy",  64'(bus.busy), 64'd0);
    check_frame("mr_out", '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.freq_valid) pulses++;
    end
    check_eq("mr_no_partial", 64'(pulses), 64'd0);
    send_frame({5{32'h4000_0000}});
    wait_valid(lat);
    check_eq("mr_lat", 64'(lat), 64'(LAT));
    check_frame("mr_next", {5{16'd2000}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
